// File: rtl/sha256_pkg.sv
// Shared constants and the padder state type for the SHA-256 front end.
// Imported by the padder RTL and by its testbench.
package sha256_pkg;

    localparam int SHA256_BLOCK_W     = 512;
    localparam int SHA256_LEN_FIELD_W = 64;
    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_SEND_DATA = 2'd1,
        ST_SEND_PAD  = 2'd2,
        ST_SEND_LAST = 2'd3
    } padder_state_e;

endpackage

// File: rtl/sha256_block_padder_if.sv
// Word-in / block-out bundle around the padder; master is the message source
// and block consumer, slave is the padder itself.
interface sha256_block_padder_if;
    import sha256_pkg::*;

    logic [31:0]               word_i;
    logic                      word_valid_i;
    logic                      word_last_i;
    logic [2:0]                word_bytes_i;
    logic                      word_ready_o;
    logic [SHA256_BLOCK_W-1:0] block_o;
    logic                      block_valid_o;
    logic                      block_ready_i;
    logic                      new_hash_o;
    logic                      last_o;

    // Words move on word_valid_i & word_ready_o, blocks on block_valid_o &
    // block_ready_i; a source must hold its payload until the transfer happens.
    modport master (
        output word_i, word_valid_i, word_last_i, word_bytes_i, block_ready_i,
        input  word_ready_o, block_o, block_valid_o, new_hash_o, last_o
    );

    modport slave (
        input  word_i, word_valid_i, word_last_i, word_bytes_i, block_ready_i,
        output word_ready_o, block_o, block_valid_o, new_hash_o, last_o
    );

endinterface

// File: rtl/sha256_block_padder.sv
// Packs big-endian message words into 512-bit SHA-256 blocks and appends the
// 0x80 marker, zero fill and 64-bit bit-length field.
module sha256_block_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               word_i,
    input  logic                      word_valid_i,
    input  logic                      word_last_i,
    input  logic [2:0]                word_bytes_i,
    output logic                      word_ready_o,
    output logic [SHA256_BLOCK_W-1:0] block_o,
    output logic                      block_valid_o,
    input  logic                      block_ready_i,
    output logic                      new_hash_o,
    output logic                      last_o,
    output padder_state_e             state_o
);

    padder_state_e             state_q, state_d;
    logic [SHA256_BLOCK_W-1:0] buf_q, buf_d;
    logic [6:0]                b_q, b_d, b_nx;
    logic [LEN_W-1:0]          cnt_q, cnt_d, cnt_nx;
    logic                      first_q, first_d;
    logic [2:0]                n_bytes;
    logic                      word_fire, block_fire;

    function automatic logic [SHA256_LEN_FIELD_W-1:0] len_field(input logic [LEN_W-1:0] c);
        logic [SHA256_LEN_FIELD_W-1:0] f;
        f = '0;
        f[LEN_W+2:3] = c;
        return f;
    endfunction

    assign word_ready_o  = (state_q == ST_FILL) && !rst_i;
    assign block_valid_o = (state_q != ST_FILL);
    assign new_hash_o    = block_valid_o && first_q;
    assign last_o        = (state_q == ST_SEND_LAST);
    assign block_o       = buf_q;
    assign state_o       = state_q;
    assign word_fire     = word_valid_i && word_ready_o;
    assign block_fire    = block_valid_o && block_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
            buf_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        n_bytes = 3'd4;
        if (word_last_i) begin
            n_bytes = (word_bytes_i > 3'd4) ? 3'd4 : word_bytes_i;
        end
        b_nx   = b_q + {4'b0, n_bytes};
        cnt_nx = cnt_q + LEN_W'(n_bytes);

        unique case (state_q)
            ST_FILL: begin
                if (word_fire) begin
                    // b is word aligned here, so a word never straddles the block end.
                    for (int k = 0; k < 4; k++) begin
                        if (k < int'(n_bytes)) begin
                            buf_d[511 - 8*(int'(b_q) + k) -: 8] = word_i[31 - 8*k -: 8];
                        end
                    end
                    b_d   = b_nx;
                    cnt_d = cnt_nx;
                    if (word_last_i) begin
                        if (b_nx <= 7'd63) begin
                            buf_d[511 - 8*int'(b_nx) -: 8] = SHA256_PAD_BYTE;
                        end
                        if (b_nx <= 7'd55) begin
                            buf_d[SHA256_LEN_FIELD_W-1:0] = len_field(cnt_nx);
                            state_d = ST_SEND_LAST;
                        end else begin
                            state_d = ST_SEND_PAD;
                        end
                    end else if (b_nx == 7'd64) begin
                        state_d = ST_SEND_DATA;
                    end
                end
            end
            ST_SEND_DATA: begin
                if (block_fire) begin
                    buf_d   = '0;
                    b_d     = '0;
                    first_d = 1'b0;
                    state_d = ST_FILL;
                end
            end
            ST_SEND_PAD: begin
                if (block_fire) begin
                    // A full final data block still owes the 0x80 marker.
                    buf_d = '0;
                    if (b_q == 7'd64) begin
                        buf_d[511:504] = SHA256_PAD_BYTE;
                    end
                    buf_d[SHA256_LEN_FIELD_W-1:0] = len_field(cnt_q);
                    first_d = 1'b0;
                    state_d = ST_SEND_LAST;
                end
            end
            ST_SEND_LAST: begin
                if (block_fire) begin
                    buf_d   = '0;
                    b_d     = '0;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

endmodule
